regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (WEN/wsel/wdat) among N

---
 rtl/regfile_wb_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file's single write port.
// Accepted beats are registered (latency 1). A 32-bit pending-write
// scoreboard is kept alongside for the issue stage's RAW hazard checks.
module regfile_wb_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*5-1:0]   req_wsel,
    input  logic [NREQ*32-1:0]  req_wdat,
    output logic [NREQ-1:0]     req_ready,
    input  logic                hold,
    input  logic                mark_valid,
    input  logic [4:0]          mark_sel,
    output logic                wen,
    output logic [4:0]          wsel,
    output logic [31:0]         wdat,
    output logic [IDW-1:0]      grant_id,
    output logic [31:0]         pending
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           wen_q, wen_d;
    logic [4:0]     wsel_q, wsel_d;
    logic [31:0]    wdat_q, wdat_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [31:0]    pending_q, pending_d;

    logic           found_hi, found_lo, accept;
    logic [IDW-1:0] gnt_hi, gnt_lo, gnt;
    logic [4:0]     beat_wsel;
    logic [31:0]    beat_wdat;

    // Rotating priority as two passes: first valid at/above ptr, else lowest valid
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        gnt_hi   = '0;
        gnt_lo   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_valid[i] && !found_lo) begin
                found_lo = 1'b1;
                gnt_lo   = IDW'(i);
            end
            if (req_valid[i] && !found_hi && (i >= 32'(ptr_q))) begin
                found_hi = 1'b1;
                gnt_hi   = IDW'(i);
            end
        end
        gnt    = found_hi ? gnt_hi : gnt_lo;
        accept = found_lo && !hold && !RST;
    end

    // One-hot ready and the granted beat, selected by OR-ing the one-hot lanes
    always_comb begin
        req_ready = '0;
        beat_wsel = '0;
        beat_wdat = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (IDW'(i) == gnt);
            if (req_ready[i]) begin
                beat_wsel = beat_wsel | req_wsel[5*i +: 5];
                beat_wdat = beat_wdat | req_wdat[32*i +: 32];
            end
        end
    end

    // Next state for the pointer, output stage and scoreboard
    always_comb begin
        ptr_d      = ptr_q;
        wen_d      = 1'b0;
        wsel_d     = wsel_q;
        wdat_d     = wdat_q;
        grant_id_d = grant_id_q;
        pending_d  = pending_q;
        if (accept) begin
            ptr_d      = (32'(gnt) == 32'(NREQ - 1)) ? '0 : gnt + 1'b1;
            wen_d      = (beat_wsel != 5'd0);
            wsel_d     = beat_wsel;
            wdat_d     = beat_wdat;
            grant_id_d = gnt;
            pending_d[beat_wsel] = 1'b0;
        end
        // set after clear so a newly issued writer wins over the retiring one
        if (mark_valid && (mark_sel != 5'd0)) begin
            pending_d[mark_sel] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q      <= '0;
            wen_q      <= 1'b0;
            wsel_q     <= '0;
            wdat_q     <= '0;
            grant_id_q <= '0;
            pending_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wen_q      <= wen_d;
            wsel_q     <= wsel_d;
            wdat_q     <= wdat_d;
            grant_id_q <= grant_id_d;
            pending_q  <= pending_d;
        end
    end

    assign wen      = wen_q;
    assign wsel     = wsel_q;
    assign wdat     = wdat_q;
    assign grant_id = grant_id_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               CLK = 1'b0;
    logic               RST;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*5-1:0]  req_wsel;
    logic [NREQ*32-1:0] req_wdat;
    logic [NREQ-1:0]    req_ready;
    logic               hold;
    logic               mark_valid;
    logic [4:0]         mark_sel;
    logic               wen;
    logic [4:0]         wsel;
    logic [31:0]        wdat;
    logic [IDW-1:0]     grant_id;
    logic [31:0]        pending;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    regfile_wb_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_wsel(req_wsel), .req_wdat(req_wdat),
        .req_ready(req_ready), .hold(hold),
        .mark_valid(mark_valid), .mark_sel(mark_sel),
        .wen(wen), .wsel(wsel), .wdat(wdat), .grant_id(grant_id),
        .pending(pending)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] ptr;
        logic        wen;
        logic [4:0]  wsel;
        logic [31:0] wdat;
        logic [31:0] gid;
        logic [31:0] pend;
    } model_t;

    model_t m;

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (p + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_ready(input model_t cur, input logic rst,
                                                    input logic h, input logic [NREQ-1:0] v);
        logic [NREQ-1:0] r;
        int g;
        r = '0;
        g = pick(v, int'(cur.ptr));
        if (!rst && !h && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic model_t model_next(input model_t cur, input logic rst, input logic h,
                                          input logic [NREQ-1:0] v, input logic [NREQ*5-1:0] ws,
                                          input logic [NREQ*32-1:0] wd, input logic mv,
                                          input logic [4:0] ms);
        model_t n;
        int g;
        logic [4:0] bw;
        if (rst) begin
            n = '0;
            return n;
        end
        n = cur;
        n.wen = 1'b0;
        g = h ? -1 : pick(v, int'(cur.ptr));
        if (g >= 0) begin
            bw = ws[g*5 +: 5];
            n.wen  = (bw != 5'd0);
            n.wsel = bw;
            n.wdat = wd[g*32 +: 32];
            n.gid  = 32'(g);
            n.ptr  = 32'((g + 1) % NREQ);
            n.pend[bw] = 1'b0;
        end
        if (mv && ms != 5'd0) n.pend[ms] = 1'b1;
        n.pend[0] = 1'b0;
        return n;
    endfunction

    always @(posedge CLK)
        m <= model_next(m, RST, hold, req_valid, req_wsel, req_wdat, mark_valid, mark_sel);

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [NREQ-1:0]    pv, pr;
    logic [NREQ*5-1:0]  pws;
    logic [NREQ*32-1:0] pwd;
    logic               prst;

    // Per-cycle compare against the model plus requester-protocol monitor
    always @(negedge CLK) begin
        if (chk_en) begin
            check("req_ready", 64'(req_ready), 64'(model_ready(m, RST, hold, req_valid)));
            check("wen",       64'(wen),       64'(m.wen));
            check("wsel",      64'(wsel),      64'(m.wsel));
            check("wdat",      64'(wdat),      64'(m.wdat));
            check("grant_id",  64'(grant_id),  64'(m.gid));
            check("pending",   64'(pending),   64'(m.pend));
            for (int i = 0; i < NREQ; i++) begin
                if (pv[i] && !pr[i] && !prst &&
                    (!req_valid[i] || req_wsel[i*5 +: 5] != pws[i*5 +: 5] ||
                     req_wdat[i*32 +: 32] != pwd[i*32 +: 32])) begin
                    errors++;
                    $display("FAIL protocol req%0d changed before ready at %0t", i, $time);
                end
            end
        end
        pv   <= req_valid;
        pws  <= req_wsel;
        pwd  <= req_wdat;
        pr   <= req_ready;
        prst <= RST;
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic setreq(input int i, input logic [4:0] ws, input logic [31:0] wd);
        req_valid[i]         = 1'b1;
        req_wsel[i*5 +: 5]   = ws;
        req_wdat[i*32 +: 32] = wd;
    endtask

    initial begin
        RST = 1'b1; hold = 1'b0; mark_valid = 1'b0; mark_sel = '0;
        req_valid = '0; req_wsel = '0; req_wdat = '0;
        cyc();
        chk_en = 1'b1;

        // reset with every requester valid
        for (int i = 0; i < NREQ; i++) setreq(i, 5'(i + 1), $urandom);
        @(negedge CLK); check("t1_ready", 64'(req_ready), 64'h0);
        cyc();
        RST = 1'b0; req_valid = '0;
        @(negedge CLK);
        check("t1_wen", 64'(wen), 64'h0);
        check("t1_pending", 64'(pending), 64'h0);
        check("model_ptr_reset", 64'(m.ptr), 64'h0);
        cyc();

        // single request
        setreq(0, 5'd5, 32'hDEADBEEF);
        @(negedge CLK); check("t2_ready", 64'(req_ready), 64'h1);
        cyc();
        req_valid[0] = 1'b0;
        @(negedge CLK);
        check("t2_wen", 64'(wen), 64'h1);
        check("t2_wsel", 64'(wsel), 64'd5);
        check("t2_wdat", 64'(wdat), 64'hDEADBEEF);
        check("t2_gid", 64'(grant_id), 64'h0);
        check("model_wdat", 64'(m.wdat), 64'hDEADBEEF);
        cyc();

        // fairness from ptr=0; requesters leave only after their grant
        RST = 1'b1;
        @(negedge CLK);
        cyc();
        RST = 1'b0;
        for (int i = 0; i < NREQ; i++) setreq(i, 5'(i + 1), 32'h100 + 32'(i));
        for (int c = 0; c < 11; c++) begin
            for (int i = 0; i < NREQ; i++)
                req_valid[i] = (c < 8) || (i < 3 && i >= c - 8);
            @(negedge CLK);
            check("t3_ready", 64'(req_ready), 64'(1 << (c % 4)));
            if (c >= 1) begin
                check("t3_wen", 64'(wen), 64'h1);
                check("t3_gid", 64'((c - 1) % 4), 64'(grant_id));
            end
            cyc();
        end
        req_valid = '0;
        @(negedge CLK); check("t3_last_gid", 64'(grant_id), 64'd2);
        cyc();

        // write to r0 (ptr=3, so search 3,0,1,2)
        setreq(2, 5'd0, 32'h12345678);
        @(negedge CLK); check("t4_ready", 64'(req_ready), 64'h4);
        cyc();
        req_valid[2] = 1'b0;
        @(negedge CLK);
        check("t4_wen", 64'(wen), 64'h0);
        check("t4_pend0", 64'(pending[0]), 64'h0);
        cyc();

        // scoreboard: mark r7 at t, cleared by beat accepted at t+3
        mark_valid = 1'b1; mark_sel = 5'd7;
        @(negedge CLK); check("t5_p7_t", 64'(pending[7]), 64'h0);
        cyc();
        mark_valid = 1'b0;
        @(negedge CLK); check("t5_p7_t1", 64'(pending[7]), 64'h1);
        cyc();
        @(negedge CLK); check("t5_p7_t2", 64'(pending[7]), 64'h1);
        cyc();
        setreq(1, 5'd7, 32'hA5A5A5A5);
        @(negedge CLK);
        check("t5_p7_t3", 64'(pending[7]), 64'h1);
        check("t5_ready", 64'(req_ready), 64'h2);
        cyc();
        req_valid[1] = 1'b0;
        @(negedge CLK); check("t5_p7_t4", 64'(pending[7]), 64'h0);
        cyc();

        // same-cycle mark and clear of r7: set wins
        mark_valid = 1'b1; mark_sel = 5'd7;
        @(negedge CLK);
        cyc();
        setreq(1, 5'd7, 32'h0BADF00D);
        @(negedge CLK); check("t5b_ready", 64'(req_ready), 64'h2);
        cyc();
        mark_valid = 1'b0; req_valid[1] = 1'b0;
        @(negedge CLK); check("t5b_p7_set_wins", 64'(pending[7]), 64'h1);
        cyc();
        setreq(1, 5'd7, 32'h0000CAFE);
        @(negedge CLK);
        cyc();
        req_valid[1] = 1'b0;
        @(negedge CLK); check("t5b_p7_cleared", 64'(pending[7]), 64'h0);
        cyc();

        // hold for 3 cycles with req1 and req3 valid, from ptr=0
        RST = 1'b1;
        @(negedge CLK);
        cyc();
        RST = 1'b0;
        setreq(1, 5'd9, 32'h11111111);
        setreq(3, 5'd10, 32'h33333333);
        hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(negedge CLK);
            check("t6_hold_ready", 64'(req_ready), 64'h0);
            check("t6_hold_wen", 64'(wen), 64'h0);
            cyc();
        end
        hold = 1'b0;
        @(negedge CLK);
        check("t6_ready1", 64'(req_ready), 64'h2);
        check("t6_wen_after", 64'(wen), 64'h0);
        cyc();
        req_valid[1] = 1'b0;
        @(negedge CLK);
        check("t6_ready3", 64'(req_ready), 64'h8);
        check("t6_gid1", 64'(grant_id), 64'd1);
        cyc();
        req_valid[3] = 1'b0;
        @(negedge CLK);
        check("t6_gid3", 64'(grant_id), 64'd3);
        check("t6_wdat3", 64'(wdat), 64'h33333333);
        cyc();

        // randomized traffic obeying the requester protocol
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && pr[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(2) == 0)
                    setreq(i, ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31)), $urandom);
            end
            hold       = ($urandom_range(7) == 0);
            RST        = ($urandom_range(99) == 0);
            mark_valid = ($urandom_range(1) == 1);
            mark_sel   = 5'($urandom_range(31));
            cyc();
        end

        @(negedge CLK);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
